// File: rtl/uvme_cvmcu_probe_pkg.sv
// Shared types and helpers for the CORE-V MCU probe sampler.
package uvme_cvmcu_probe_pkg;

  // Sampling mode selected by mode_i.
  typedef enum logic {
    PROBE_ON_CHANGE = 1'b0,
    PROBE_PERIODIC  = 1'b1
  } uvme_cvmcu_probe_mode_e;

  // Default event field widths (NUM_CH=4, DATA_W=8, TS_W=32).
  localparam int unsigned PROBE_DEF_CH_W   = 2;
  localparam int unsigned PROBE_DEF_DATA_W = 8;
  localparam int unsigned PROBE_DEF_TS_W   = 32;

  // Event record at default widths; the sampler re-declares it with its own parameters.
  typedef struct packed {
    logic [PROBE_DEF_CH_W-1:0]   ch;
    logic [PROBE_DEF_DATA_W-1:0] data;
    logic [PROBE_DEF_TS_W-1:0]   ts;
  } uvme_cvmcu_probe_evt_t;

  // 16-bit add that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] probe_sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/uvme_cvmcu_probe_fifo.sv
// Synchronous first-word-fall-through event FIFO with flush.
module uvme_cvmcu_probe_fifo
  import uvme_cvmcu_probe_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LVL_W-1:0] level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] cnt_q, cnt_d;
  logic             do_push_s, do_pop_s;

  assign full_o  = (cnt_q == LVL_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign level_o = cnt_q;
  // Head is forced to zero when empty so no stale entry is ever visible.
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // Qualify push/pop (pop on empty ignored, push on full only with a pop) and next occupancy.
  always_comb begin
    do_pop_s  = pop_i & ~empty_o;
    do_push_s = push_i & (~full_o | do_pop_s);
    if (do_push_s && !do_pop_s) begin
      cnt_d = cnt_q + LVL_W'(1);
    end else if (!do_push_s && do_pop_s) begin
      cnt_d = cnt_q - LVL_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Pointer and occupancy state; flush behaves like reset for the queue.
  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push_s) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop_s)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      cnt_q <= cnt_d;
    end
  end

  // Storage write; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push_s && !flush_i && !reset) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/uvme_cvmcu_probe_sampler.sv
// Multi-channel probe sampler: change/periodic detection, per-channel pending
// slots with loss accounting, round-robin arbitration into an event FIFO.
module uvme_cvmcu_probe_sampler
  import uvme_cvmcu_probe_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned TS_W   = 32,
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH*DATA_W-1:0] probe_i,
  input  logic                     enable_i,
  input  logic                     mode_i,
  input  logic [15:0]              period_i,
  input  logic [NUM_CH-1:0]        ch_mask_i,
  input  logic                     clear_i,
  output logic                     evt_valid_o,
  input  logic                     evt_ready_i,
  output logic [CH_W-1:0]          evt_ch_o,
  output logic [DATA_W-1:0]        evt_data_o,
  output logic [TS_W-1:0]          evt_ts_o,
  output logic [LVL_W-1:0]         level_o,
  output logic                     overflow_o,
  output logic [15:0]              drop_cnt_o
);

  typedef struct packed {
    logic [CH_W-1:0]   ch;
    logic [DATA_W-1:0] data;
    logic [TS_W-1:0]   ts;
  } evt_t;

  logic [NUM_CH-1:0][DATA_W-1:0] probe_s, prev_q, pdata_q, pdata_d;
  logic [NUM_CH-1:0][TS_W-1:0]   pts_q, pts_d;
  logic [NUM_CH-1:0]             pend_q, pend_d, ev_s;
  logic [TS_W-1:0]               ts_q;
  logic [15:0]                   per_cnt_q, per_cnt_d, drop_q, drop_d, n_drop_s;
  logic [CH_W-1:0]               rr_q, rr_d, win_s;
  logic                          primed_q, ovf_q, ovf_d;
  logic                          per_act_s, per_wrap_s, win_found_s, push_s, pop_s, fifo_full_s, fifo_empty_s;
  uvme_cvmcu_probe_mode_e        mode_s;
  evt_t                          push_evt_s, head_s;

  assign probe_s = probe_i;
  assign mode_s  = uvme_cvmcu_probe_mode_e'(mode_i);
  assign pop_s   = evt_valid_o & evt_ready_i;

  // Period counter runs 0..period_i only while enabled in periodic mode, else parks at 0.
  always_comb begin
    per_act_s  = enable_i && (mode_s == PROBE_PERIODIC);
    per_wrap_s = per_act_s && (per_cnt_q >= period_i);
    if (!per_act_s || per_wrap_s) begin
      per_cnt_d = 16'd0;
    end else begin
      per_cnt_d = per_cnt_q + 16'd1;
    end
  end

  // Per-channel event request: change vs. previous sample, or periodic wrap.
  always_comb begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (mode_s == PROBE_PERIODIC) begin
        ev_s[c] = enable_i & primed_q & ch_mask_i[c] & per_wrap_s;
      end else begin
        ev_s[c] = enable_i & primed_q & ch_mask_i[c] & (probe_s[c] != prev_q[c]);
      end
    end
  end

  // Round-robin pick of the first pending channel at or after the pointer.
  always_comb begin
    win_found_s = 1'b0;
    win_s       = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      int unsigned idx;
      idx = (32'(rr_q) + k) % NUM_CH;
      if (!win_found_s && pend_q[idx]) begin
        win_found_s = 1'b1;
        win_s       = CH_W'(idx);
      end else begin
        win_found_s = win_found_s;
      end
    end
    push_s            = win_found_s & (~fifo_full_s | pop_s) & ~clear_i;
    push_evt_s.ch     = win_s;
    push_evt_s.data   = pdata_q[win_s];
    push_evt_s.ts     = pts_q[win_s];
    if (push_s) begin
      rr_d = CH_W'((32'(win_s) + 32'd1) % NUM_CH);
    end else begin
      rr_d = rr_q;
    end
  end

  // Pending slot update; a new event on an already-pending channel is counted as lost.
  always_comb begin
    pend_d   = pend_q;
    pdata_d  = pdata_q;
    pts_d    = pts_q;
    n_drop_s = 16'd0;
    if (push_s) begin
      pend_d[win_s] = 1'b0;
    end else begin
      pend_d = pend_q;
    end
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (ev_s[c] && pend_q[c]) begin
        n_drop_s = n_drop_s + 16'd1;
      end else if (ev_s[c]) begin
        pend_d[c]  = 1'b1;
        pdata_d[c] = probe_s[c];
        pts_d[c]   = ts_q;
      end else begin
        pend_d[c] = pend_d[c];
      end
    end
    drop_d = probe_sat_add16(drop_q, n_drop_s);
    ovf_d  = ovf_q | (n_drop_s != 16'd0);
  end

  // Free-running timestamp and period counter; clear_i does not touch them.
  always_ff @(posedge clk) begin
    if (reset) begin
      ts_q      <= '0;
      per_cnt_q <= 16'd0;
    end else begin
      ts_q      <= ts_q + TS_W'(1);
      per_cnt_q <= per_cnt_d;
    end
  end

  // Previous-sample tracking follows every enabled cycle, masked or not.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= '0;
    end else if (enable_i) begin
      prev_q <= probe_s;
    end else begin
      prev_q <= prev_q;
    end
  end

  // Pending slots, arbiter pointer, priming and loss accounting; clear_i wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q   <= '0;
      pdata_q  <= '0;
      pts_q    <= '0;
      rr_q     <= '0;
      primed_q <= 1'b0;
      drop_q   <= 16'd0;
      ovf_q    <= 1'b0;
    end else if (clear_i) begin
      pend_q   <= '0;
      primed_q <= 1'b0;
      drop_q   <= 16'd0;
      ovf_q    <= 1'b0;
    end else begin
      pend_q   <= pend_d;
      pdata_q  <= pdata_d;
      pts_q    <= pts_d;
      rr_q     <= rr_d;
      drop_q   <= drop_d;
      ovf_q    <= ovf_d;
      primed_q <= primed_q | enable_i;
    end
  end

  uvme_cvmcu_probe_fifo #(
    .WIDTH($bits(evt_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush_i (clear_i),
    .push_i  (push_s),
    .wdata_i (push_evt_s),
    .pop_i   (pop_s),
    .rdata_o (head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .level_o (level_o)
  );

  assign evt_valid_o = ~fifo_empty_s;
  assign evt_ch_o    = head_s.ch;
  assign evt_data_o  = head_s.data;
  assign evt_ts_o    = head_s.ts;
  assign overflow_o  = ovf_q;
  assign drop_cnt_o  = drop_q;

endmodule

// File: tb/tb_uvme_cvmcu_probe_sampler.sv
// Self-checking bench for uvme_cvmcu_probe_sampler (NUM_CH=4, DATA_W=8, DEPTH=16, TS_W=8).
module tb_uvme_cvmcu_probe_sampler;
  localparam int NCH = 4;
  localparam int DEP = 16;
  localparam int TSM = 256;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] probe = 32'd0;
  logic        enable = 1'b0, mode = 1'b0, clear = 1'b0, ready = 1'b1;
  logic [15:0] period = 16'd0;
  logic [3:0]  mask = 4'hF;
  logic        valid, ovf;
  logic [1:0]  ch;
  logic [7:0]  data, ts;
  logic [4:0]  level;
  logic [15:0] drop;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {int ch; int data; int ts;} mevt_t;
  mevt_t m_q[$];
  int    m_ts, m_cnt, m_rr, m_drop;
  bit    m_primed, m_ovf;
  int    m_prev[NCH], m_pdata[NCH], m_pts[NCH];
  bit    m_pend[NCH];

  uvme_cvmcu_probe_sampler #(.NUM_CH(4), .DATA_W(8), .DEPTH(16), .TS_W(8)) dut (
    .clk(clk), .reset(reset), .probe_i(probe), .enable_i(enable), .mode_i(mode),
    .period_i(period), .ch_mask_i(mask), .clear_i(clear), .evt_valid_o(valid),
    .evt_ready_i(ready), .evt_ch_o(ch), .evt_data_o(data), .evt_ts_o(ts),
    .level_o(level), .overflow_o(ovf), .drop_cnt_o(drop)
  );

  always #5 clk = ~clk;

  // Behavioural model: what the sampler does at the coming edge given current inputs.
  task automatic model_step();
    bit pop, push, found, act, wrap, ev, oldp[NCH];
    int w, n;
    mevt_t e;
    if (reset) begin
      m_ts = 0; m_cnt = 0; m_rr = 0; m_drop = 0; m_primed = 0; m_ovf = 0;
      for (int c = 0; c < NCH; c++) begin m_prev[c] = 0; m_pend[c] = 0; m_pdata[c] = 0; m_pts[c] = 0; end
      m_q.delete();
      return;
    end
    pop = (m_q.size() != 0) && ready;
    found = 0; w = 0;
    for (int k = 0; k < NCH; k++) if (!found && m_pend[(m_rr + k) % NCH]) begin found = 1; w = (m_rr + k) % NCH; end
    push = found && (m_q.size() < DEP || pop) && !clear;
    act = enable && mode;
    wrap = act && (m_cnt >= int'(period));
    for (int c = 0; c < NCH; c++) oldp[c] = m_pend[c];
    if (clear) begin
      m_q.delete();
      for (int c = 0; c < NCH; c++) m_pend[c] = 0;
      m_drop = 0; m_ovf = 0; m_primed = 0;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (push) begin
        e.ch = w; e.data = m_pdata[w]; e.ts = m_pts[w];
        m_q.push_back(e);
        m_pend[w] = 0;
        m_rr = (w + 1) % NCH;
      end
      n = 0;
      for (int c = 0; c < NCH; c++) begin
        ev = enable && m_primed && mask[c] && (mode ? wrap : (int'(probe[c*8 +: 8]) != m_prev[c]));
        if (ev && oldp[c]) n++;
        else if (ev) begin m_pend[c] = 1; m_pdata[c] = int'(probe[c*8 +: 8]); m_pts[c] = m_ts; end
      end
      m_drop = (m_drop + n > 65535) ? 65535 : m_drop + n;
      if (n > 0) m_ovf = 1;
      if (enable) m_primed = 1;
    end
    m_cnt = act ? (wrap ? 0 : m_cnt + 1) : 0;
    if (enable) for (int c = 0; c < NCH; c++) m_prev[c] = int'(probe[c*8 +: 8]);
    m_ts = (m_ts + 1) % TSM;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; mode = 1'b0; period = 16'd0; mask = 4'hF;
    clear = 1'b0; ready = 1'b1; probe = 32'd0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%0b exp=0", valid); end
    n_cmp++; if (level !== 5'd0) begin n_fail++; $display("FAIL rst_level got=%0d exp=0", level); end
    n_cmp++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL rst_ovf got=%0b exp=0", ovf); end
    n_cmp++; if (drop !== 16'd0) begin n_fail++; $display("FAIL rst_drop got=%0d exp=0", drop); end
    n_cmp++; if ({ch, data, ts} !== 18'd0) begin n_fail++; $display("FAIL rst_evt got=%0h exp=0", {ch, data, ts}); end
  endtask

  task automatic test_single_change();
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 300 && m_ts != 100; i++) tick();
    probe[23:16] = 8'h5A;
    tick();
    n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL single_early got=%0b exp=0", valid); end
    tick();
    n_cmp++; if (valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got=%0b exp=1", valid); end
    n_cmp++; if ({ch, data, ts} !== {2'd2, 8'h5A, 8'd100}) begin n_fail++;
      $display("FAIL single_evt got=ch%0d/%0h/%0d exp=ch2/5a/100", ch, data, ts); end
    tick();
    n_cmp++; if (valid !== 1'b0 || level !== 5'd0) begin n_fail++; $display("FAIL single_drain got=%0b/%0d exp=0/0", valid, level); end
  endtask

  task automatic test_all_change();
    logic [31:0] v;
    int exp_ts;
    do_reset();
    enable = 1'b1;
    tick();
    for (int c = 0; c < NCH; c++) v[c*8 +: 8] = 8'($urandom_range(255, 1));
    probe = v;
    exp_ts = m_ts;
    tick();
    for (int k = 0; k < NCH; k++) begin
      tick();
      n_cmp++; if (valid !== 1'b1 || ch !== 2'(k) || data !== v[k*8 +: 8] || ts !== 8'(exp_ts)) begin n_fail++;
        $display("FAIL all_evt%0d got=%0b ch%0d/%0h/%0d exp=1 ch%0d/%0h/%0d", k, valid, ch, data, ts, k, v[k*8 +: 8], exp_ts); end
    end
  endtask

  task automatic test_collision();
    do_reset();
    enable = 1'b1; ready = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin probe[15:8] = ~probe[15:8]; tick(); end
    n_cmp++; if (drop !== 16'd5 || drop !== 16'(m_drop)) begin n_fail++; $display("FAIL coll_drop got=%0d exp=5", drop); end
    n_cmp++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL coll_ovf got=%0b exp=1", ovf); end
    n_cmp++; if (level !== 5'd5) begin n_fail++; $display("FAIL coll_level got=%0d exp=5", level); end
    n_cmp++; if (ch !== 2'd1 || data !== 8'hFF) begin n_fail++; $display("FAIL coll_head got=ch%0d/%0h exp=ch1/ff", ch, data); end
  endtask

  task automatic test_fill_backpressure();
    mevt_t exp_l[$];
    mevt_t e;
    do_reset();
    enable = 1'b1; ready = 1'b0;
    tick();
    for (int i = 0; i < 20; i++) begin
      e.ch = i % NCH;
      e.data = int'(probe[e.ch*8 +: 8] ^ 8'($urandom_range(255, 1)));
      probe[e.ch*8 +: 8] = 8'(e.data);
      exp_l.push_back(e);
      tick(); tick();
      n_cmp++; if (valid !== 1'b1 || ch !== 2'(exp_l[0].ch) || data !== 8'(exp_l[0].data)) begin n_fail++;
        $display("FAIL fill_hold%0d got=%0b ch%0d/%0h exp=1 ch%0d/%0h", i, valid, ch, data, exp_l[0].ch, exp_l[0].data); end
    end
    n_cmp++; if (level !== 5'd16) begin n_fail++; $display("FAIL fill_level got=%0d exp=16", level); end
    n_cmp++; if (drop !== 16'd0 || ovf !== 1'b0) begin n_fail++; $display("FAIL fill_nodrop got=%0d/%0b exp=0/0", drop, ovf); end
    ready = 1'b1;
    for (int j = 0; j < 20; j++) begin
      n_cmp++; if (valid !== 1'b1 || ch !== 2'(exp_l[j].ch) || data !== 8'(exp_l[j].data) || ts !== 8'(m_q[0].ts)) begin n_fail++;
        $display("FAIL drain%0d got=%0b ch%0d/%0h/%0d exp=1 ch%0d/%0h/%0d", j, valid, ch, data, ts, exp_l[j].ch, exp_l[j].data, m_q[0].ts); end
      tick();
    end
    n_cmp++; if (valid !== 1'b0 || level !== 5'd0) begin n_fail++; $display("FAIL drain_end got=%0b/%0d exp=0/0", valid, level); end
  endtask

  task automatic test_periodic();
    int seen = 0, m_seen = 0;
    do_reset();
    mode = 1'b1; period = 16'd3; mask = 4'b0101; enable = 1'b1;
    for (int i = 0; i < 80; i++) begin
      ready = (i < 40);
      probe = $urandom;
      if (valid && ready) seen++;
      if (m_q.size() != 0 && ready) m_seen++;
      if (valid && ch != 2'd0 && ch != 2'd2) begin n_cmp++; n_fail++; $display("FAIL per_chan got=ch%0d exp=ch0/ch2", ch); end
      tick();
      n_cmp++; if (valid !== (m_q.size() != 0) || level !== 5'(m_q.size()) || drop !== 16'(m_drop)) begin n_fail++;
        $display("FAIL per_cyc%0d got=%0b/%0d/%0d exp=%0b/%0d/%0d", i, valid, level, drop, m_q.size() != 0, m_q.size(), m_drop); end
      if (m_q.size() != 0) begin
        n_cmp++; if (ch !== 2'(m_q[0].ch) || data !== 8'(m_q[0].data) || ts !== 8'(m_q[0].ts)) begin n_fail++;
          $display("FAIL per_head%0d got=ch%0d/%0h/%0d exp=ch%0d/%0h/%0d", i, ch, data, ts, m_q[0].ch, m_q[0].data, m_q[0].ts); end
      end
    end
    n_cmp++; if (seen !== m_seen || seen < 16) begin n_fail++; $display("FAIL per_count got=%0d exp=%0d", seen, m_seen); end
    n_cmp++; if (drop === 16'd0) begin n_fail++; $display("FAIL per_loss got=%0d exp=nonzero", drop); end
    clear = 1'b1; tick(); clear = 1'b0;
    n_cmp++; if (level !== 5'd0 || drop !== 16'd0 || ovf !== 1'b0 || valid !== 1'b0) begin n_fail++;
      $display("FAIL per_clear got=%0d/%0d/%0b/%0b exp=0/0/0/0", level, drop, ovf, valid); end
  endtask

  task automatic test_ts_wrap();
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 300 && m_ts != 255; i++) tick();
    probe[7:0] = 8'h11; tick();
    probe[15:8] = 8'h22; tick();
    n_cmp++; if (valid !== 1'b1 || ch !== 2'd0 || ts !== 8'd255) begin n_fail++; $display("FAIL wrap_a got=%0b ch%0d ts%0d exp=1 ch0 ts255", valid, ch, ts); end
    tick();
    n_cmp++; if (valid !== 1'b1 || ch !== 2'd1 || ts !== 8'd0) begin n_fail++; $display("FAIL wrap_b got=%0b ch%0d ts%0d exp=1 ch1 ts0", valid, ch, ts); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    enable = 1'b1; ready = 1'b0;
    tick();
    probe = 32'h01020304; tick(); tick(); tick(); tick(); tick();
    n_cmp++; if (level !== 5'd4) begin n_fail++; $display("FAIL mid_pre got=%0d exp=4", level); end
    reset = 1'b1; tick(); reset = 1'b0;
    n_cmp++; if (valid !== 1'b0 || level !== 5'd0) begin n_fail++; $display("FAIL mid_rst got=%0b/%0d exp=0/0", valid, level); end
    ready = 1'b1; tick(); tick(); tick();
    n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale got=%0b exp=0", valid); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (i % 100 == 0) begin period = 16'($urandom_range(3, 0)); mask = 4'($urandom); end
      if (i % 50 == 0) mode = 1'($urandom);
      enable = ($urandom_range(9, 0) != 0);
      ready  = ($urandom_range(2, 0) == 0);
      clear  = ($urandom_range(60, 0) == 0);
      for (int c = 0; c < NCH; c++) if ($urandom_range(3, 0) == 0) probe[c*8 +: 8] = 8'($urandom);
      tick();
      n_cmp++; if (valid !== (m_q.size() != 0) || level !== 5'(m_q.size()) || drop !== 16'(m_drop) || ovf !== m_ovf) begin n_fail++;
        $display("FAIL rnd_stat%0d got=%0b/%0d/%0d/%0b exp=%0b/%0d/%0d/%0b", i, valid, level, drop, ovf, m_q.size() != 0, m_q.size(), m_drop, m_ovf); end
      if (m_q.size() != 0) begin
        n_cmp++; if (ch !== 2'(m_q[0].ch) || data !== 8'(m_q[0].data) || ts !== 8'(m_q[0].ts)) begin n_fail++;
          $display("FAIL rnd_head%0d got=ch%0d/%0h/%0d exp=ch%0d/%0h/%0d", i, ch, data, ts, m_q[0].ch, m_q[0].data, m_q[0].ts); end
      end
    end
    clear = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_change();
    test_all_change();
    test_collision();
    test_fill_backpressure();
    test_periodic();
    test_ts_wrap();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
